// File: rtl/tinker_mem_unit.sv
// Unified byte-addressed memory serving an instruction-fetch port and a data load/store port.
// Fixed LATENCY edges from accept to response; one transaction in flight at a time.
// Ready is granted to at most one port, and only when the engine is free; starvation-bounded priority.
module tinker_mem_unit #(
   parameter int unsigned MEM_BYTES  = 524288,
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 64,
   parameter int unsigned LATENCY    = 2,
   parameter int unsigned STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ready,
   output logic              i_rvalid,
   output logic [31:0]       i_rdata,
   output logic              i_err,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ready,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_err
);

   localparam int unsigned NB    = DATA_W / 8;
   localparam int unsigned IDX_W = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
   localparam int unsigned CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
   localparam int unsigned SV_W  = $clog2(STARVE_MAX + 1);
   localparam logic [ADDR_W:0] MEM_END = (ADDR_W+1)'(MEM_BYTES);

   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [SV_W-1:0]   starve_q, starve_d;

   // Latched request of the transaction in flight (port_q: 1 = data port)
   logic              port_q;
   logic              we_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;

   logic              i_rvalid_q, d_rvalid_q, i_err_q, d_err_q;
   logic [31:0]       i_rdata_q;
   logic [DATA_W-1:0] d_rdata_q;

   logic [7:0]        mem_q [MEM_BYTES];

   logic              can_accept, respond, d_sel;
   logic              oor_i, oor_d;
   logic [31:0]       rd_i;
   logic [DATA_W-1:0] rd_d;

   // Engine is free when idle or when the in-flight transaction responds on this edge
   assign can_accept = (state_q == IDLE) || (cnt_q == '0);
   assign respond    = (state_q == BUSY) && (cnt_q == '0);

   // Data wins a contested cycle unless fetch has waited STARVE_MAX data grants
   assign d_sel   = d_req && (!i_req || (starve_q != SV_W'(STARVE_MAX)));
   assign d_ready = !reset && can_accept && d_sel;
   assign i_ready = !reset && can_accept && i_req && !d_sel;

   // Range checks at ADDR_W+1 bits so addresses near the top cannot wrap into range
   assign oor_i = ({1'b0, addr_q} + (ADDR_W+1)'(4))  > MEM_END;
   assign oor_d = ({1'b0, addr_q} + (ADDR_W+1)'(NB)) > MEM_END;

   // Little-endian gather of the addressed bytes; zero when out of range
   always_comb begin
      rd_i = '0;
      rd_d = '0;
      if (!oor_i) begin
         for (int k = 0; k < 4; k++) begin
            rd_i[8*k +: 8] = mem_q[addr_q[IDX_W-1:0] + IDX_W'(k)];
         end
      end
      if (!oor_d) begin
         for (int k = 0; k < NB; k++) begin
            rd_d[8*k +: 8] = mem_q[addr_q[IDX_W-1:0] + IDX_W'(k)];
         end
      end
   end

   // Next state: count down while busy, restart on any accept, track fetch starvation
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      starve_d = starve_q;
      if (state_q == BUSY) begin
         if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
         end else begin
            state_d = IDLE;
         end
      end
      if (i_ready || d_ready) begin
         state_d = BUSY;
         cnt_d   = CNT_W'(LATENCY - 1);
      end
      if (!i_req || i_ready) begin
         starve_d = '0;
      end else if (d_ready) begin
         starve_d = starve_q + 1'b1;
      end
   end

   // Control state and registered responses
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         starve_q   <= '0;
         i_rvalid_q <= 1'b0;
         d_rvalid_q <= 1'b0;
         i_err_q    <= 1'b0;
         d_err_q    <= 1'b0;
         i_rdata_q  <= '0;
         d_rdata_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         starve_q   <= starve_d;
         i_rvalid_q <= respond && !port_q;
         d_rvalid_q <= respond && port_q;
         if (respond && port_q) begin
            d_rdata_q <= we_q ? '0 : rd_d;
            d_err_q   <= oor_d;
         end
         if (respond && !port_q) begin
            i_rdata_q <= rd_i;
            i_err_q   <= oor_i;
         end
      end
   end

   // Capture the granted request; payload needs no reset since it is only used while BUSY
   always_ff @(posedge clk) begin
      if (d_ready) begin
         port_q  <= 1'b1;
         we_q    <= d_we;
         addr_q  <= d_addr;
         wdata_q <= d_wdata;
      end else if (i_ready) begin
         port_q  <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= i_addr;
      end
   end

   // Store commits on the response edge; out-of-range stores write nothing
   always_ff @(posedge clk) begin
      if (!reset && respond && port_q && we_q && !oor_d) begin
         for (int k = 0; k < NB; k++) begin
            mem_q[addr_q[IDX_W-1:0] + IDX_W'(k)] <= wdata_q[8*k +: 8];
         end
      end
   end

   assign i_rvalid = i_rvalid_q;
   assign d_rvalid = d_rvalid_q;
   assign i_rdata  = i_rdata_q;
   assign d_rdata  = d_rdata_q;
   assign i_err    = i_err_q;
   assign d_err    = d_err_q;

endmodule
